// File: rtl/byte_serializer.sv
// -----------------------------------------------------------------------------
// byte_serializer
//
// Bit-serial transmitter. A parallel word accepted on a valid/ready handshake
// is sent on a single line as: start bit (0), data LSB-first, optional even
// parity bit, stop bit (1). Every bit is held for CYCLES_PER_BIT clocks.
//
// Optional feature macro: BYTE_SERIALIZER_PARITY_EN
//   defined   -> a PARITY bit (XOR of the data bits) sits between data and stop
//   undefined -> no parity state or logic; stop follows the last data bit
//
// Parameters
//   WIDTH          data bits per frame (>= 1)
//   CYCLES_PER_BIT clocks per bit on the line (>= 1)
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   in_data   word to send, sampled only on the accept edge
//   in_valid  producer has a word
//   in_ready  serializer idle and able to accept (registered)
//   out       serial line, idles high (registered)
//   busy      frame in progress, always ~in_ready
//   done      one-cycle pulse in the first idle cycle after a stop bit
// -----------------------------------------------------------------------------
module byte_serializer #(
  parameter int WIDTH          = 8,
  parameter int CYCLES_PER_BIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CYC_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CYC_ONE  = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ZERO = BIT_W'(0);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

`ifdef BYTE_SERIALIZER_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Even parity over the captured word.
  function automatic logic even_parity(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } state_t;
`endif

  state_t           state_r, state_next_s;
  logic [CNT_W-1:0] cyc_r, cyc_next_s;
  logic [BIT_W-1:0] bit_r, bit_next_s;
  logic [WIDTH-1:0] shift_r, shift_next_s;
  logic             out_r, out_next_s;
  logic             ready_r, ready_next_s;
  logic             done_r, done_next_s;
  logic             last_cyc_s;
`ifdef BYTE_SERIALIZER_PARITY_EN
  logic             parity_r, parity_next_s;
`endif

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      cyc_r    <= CYC_ZERO;
      bit_r    <= BIT_ZERO;
      shift_r  <= '0;
      out_r    <= 1'b1;
      ready_r  <= 1'b1;
      done_r   <= 1'b0;
`ifdef BYTE_SERIALIZER_PARITY_EN
      parity_r <= 1'b0;
`endif
    end else begin
      state_r  <= state_next_s;
      cyc_r    <= cyc_next_s;
      bit_r    <= bit_next_s;
      shift_r  <= shift_next_s;
      out_r    <= out_next_s;
      ready_r  <= ready_next_s;
      done_r   <= done_next_s;
`ifdef BYTE_SERIALIZER_PARITY_EN
      parity_r <= parity_next_s;
`endif
    end
  end

  // Next-state logic; out/in_ready/done are computed one cycle ahead so the
  // registered values line up with the state they describe.
  always_comb begin
    state_next_s  = state_r;
    cyc_next_s    = cyc_r;
    bit_next_s    = bit_r;
    shift_next_s  = shift_r;
    out_next_s    = out_r;
    ready_next_s  = 1'b0;
    done_next_s   = 1'b0;
`ifdef BYTE_SERIALIZER_PARITY_EN
    parity_next_s = parity_r;
`endif
    last_cyc_s    = (cyc_r == CYC_LAST);

    case (state_r)
      IDLE: begin
        out_next_s   = 1'b1;
        ready_next_s = 1'b1;
        if (in_valid && ready_r) begin
          state_next_s  = START;
          shift_next_s  = in_data;
          cyc_next_s    = CYC_ZERO;
          bit_next_s    = BIT_ZERO;
          out_next_s    = 1'b0;
          ready_next_s  = 1'b0;
`ifdef BYTE_SERIALIZER_PARITY_EN
          parity_next_s = even_parity(in_data);
`endif
        end else begin
          state_next_s = IDLE;
        end
      end

      START: begin
        if (last_cyc_s) begin
          // Shift register always presents the next data bit at bit 0.
          state_next_s = DATA;
          cyc_next_s   = CYC_ZERO;
          out_next_s   = shift_r[0];
          shift_next_s = shift_r >> 1;
        end else begin
          cyc_next_s = cyc_r + CYC_ONE;
        end
      end

      DATA: begin
        if (last_cyc_s) begin
          cyc_next_s = CYC_ZERO;
          if (bit_r == BIT_LAST) begin
`ifdef BYTE_SERIALIZER_PARITY_EN
            state_next_s = PARITY;
            out_next_s   = parity_r;
`else
            state_next_s = STOP;
            out_next_s   = 1'b1;
`endif
          end else begin
            bit_next_s   = bit_r + BIT_ONE;
            out_next_s   = shift_r[0];
            shift_next_s = shift_r >> 1;
          end
        end else begin
          cyc_next_s = cyc_r + CYC_ONE;
        end
      end

`ifdef BYTE_SERIALIZER_PARITY_EN
      PARITY: begin
        if (last_cyc_s) begin
          state_next_s = STOP;
          cyc_next_s   = CYC_ZERO;
          out_next_s   = 1'b1;
        end else begin
          cyc_next_s = cyc_r + CYC_ONE;
        end
      end
`endif

      STOP: begin
        if (last_cyc_s) begin
          state_next_s = IDLE;
          cyc_next_s   = CYC_ZERO;
          out_next_s   = 1'b1;
          ready_next_s = 1'b1;
          done_next_s  = 1'b1;
        end else begin
          cyc_next_s = cyc_r + CYC_ONE;
        end
      end

      default: begin
        state_next_s = IDLE;
        cyc_next_s   = CYC_ZERO;
        bit_next_s   = BIT_ZERO;
        out_next_s   = 1'b1;
        ready_next_s = 1'b1;
      end
    endcase
  end

  assign in_ready = ready_r;
  assign busy     = ~ready_r;
  assign out      = out_r;
  assign done     = done_r;

endmodule

// File: tb/tb_byte_serializer.sv
// -----------------------------------------------------------------------------
// tb_byte_serializer
//
// Drives two serializers (WIDTH=8 with C=4 and C=1) from shared inputs and
// checks every cycle against a frame model that derives the expected line
// value from the bit position inside the frame. Directed scenarios add
// hand-computed expectations on top of the random traffic.
// -----------------------------------------------------------------------------
module tb_byte_serializer;

`ifdef BYTE_SERIALIZER_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic [1:0] ready_v, out_v, busy_v, done_v;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  byte_serializer #(.WIDTH(8), .CYCLES_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ready_v[0]), .out(out_v[0]), .busy(busy_v[0]), .done(done_v[0])
  );

  byte_serializer #(.WIDTH(8), .CYCLES_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(ready_v[1]), .out(out_v[1]), .busy(busy_v[1]), .done(done_v[1])
  );

  // ---------------- reference model ----------------
  function automatic int ck(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  function automatic int frame_len(input int c);
    return c * (8 + 2 + P);
  endfunction

  // Line value at position idx (0-based) of a frame carrying d.
  function automatic logic frame_bit(input logic [7:0] d, input int c, input int idx);
    int seg;
    seg = idx / c;
    if (seg == 0) return 1'b0;
    if (seg <= 8) return d[seg-1];
    if (P == 1 && seg == 9) return ^d;
    return 1'b1;
  endfunction

  logic       m_active [2];
  int         m_pos    [2];
  logic [7:0] m_data   [2];
  logic       m_done   [2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_active[k] = 1'b0;
        m_pos[k]    = 0;
        m_done[k]   = 1'b0;
      end else if (!m_active[k] && in_valid) begin
        m_active[k] = 1'b1;
        m_pos[k]    = 0;
        m_data[k]   = in_data;
        m_done[k]   = 1'b0;
      end else if (m_active[k]) begin
        if (m_pos[k] == frame_len(ck(k)) - 1) begin
          m_active[k] = 1'b0;
          m_done[k]   = 1'b1;
        end else begin
          m_pos[k] = m_pos[k] + 1;
        end
      end else begin
        m_done[k] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both DUTs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        logic eo;
        eo = m_active[k] ? frame_bit(m_data[k], ck(k), m_pos[k]) : 1'b1;
        check($sformatf("out[%0d]", k),      int'(out_v[k]),   int'(eo));
        check($sformatf("in_ready[%0d]", k), int'(ready_v[k]), int'(!m_active[k]));
        check($sformatf("busy[%0d]", k),     int'(busy_v[k]),  int'(m_active[k]));
        check($sformatf("done[%0d]", k),     int'(done_v[k]),  int'(m_done[k]));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle();
    int n;
    n = 0;
    while (ready_v != 2'b11 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", int'(ready_v == 2'b11), 1);
  endtask

  // Returns at the negedge inside cycle 1 of the new frame.
  task automatic send(input logic [7:0] d);
    @(negedge clk);
    in_data  = d;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts cycles (current cycle = 1) until dut4 raises done.
  task automatic wait_done4(output int n);
    n = 1;
    while (!done_v[0] && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int n;
    logic [10:0] got_seq, exp_seq;

    // Model pins with hand-computed values.
    check("len_c4", frame_len(4), (P == 1) ? 44 : 40);
    check("len_c1", frame_len(1), (P == 1) ? 11 : 10);
    check("fb_start", int'(frame_bit(8'hA5, 4, 3)), 0);
    check("fb_bit0", int'(frame_bit(8'hA5, 4, 4)), 1);
    check("fb_bit1", int'(frame_bit(8'hA5, 4, 8)), 0);
    check("fb_bit7", int'(frame_bit(8'hA5, 4, 35)), 1);
    check("fb_par01", int'(frame_bit(8'h01, 4, 36)), (P == 1) ? 1 : 1);
    check("fb_par_a5", int'(frame_bit(8'hA5, 4, 37)), (P == 1) ? 0 : 1);

    // Reset
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_out", int'(out_v[0]), 1);
    check("rst_ready", int'(ready_v[0]), 1);
    check("rst_done", int'(done_v[0]), 0);

    // No handshake: in_data toggles, in_valid low.
    for (int i = 0; i < 50; i++) begin
      in_data = 8'($urandom);
      @(negedge clk);
    end
    check("idle_out", int'(out_v), 3);

    // Basic frame 0xA5
    wait_idle();
    send(8'hA5);
    wait_done4(n);
    check("a5_done_cycle", n, frame_len(4) + 1);

    // Parity-bit frame 0x01
    wait_idle();
    send(8'h01);
    wait_done4(n);
    check("01_done_cycle", n, frame_len(4) + 1);

    // C=1, 0x3C: capture the line for the whole frame.
    wait_idle();
    send(8'h3C);
    got_seq = '0;
    for (int j = 0; j < frame_len(1); j++) begin
      got_seq[j] = out_v[1];
      @(negedge clk);
    end
    check("c1_done", int'(done_v[1]), 1);
`ifdef BYTE_SERIALIZER_PARITY_EN
    exp_seq = 11'b10001111000;
`else
    exp_seq = 11'b01001111000;
`endif
    check("c1_seq", int'(got_seq), int'(exp_seq));

    // Back-to-back: 0x00 then 0xFF with in_valid held.
    wait_idle();
    @(negedge clk);
    in_data  = 8'h00;
    in_valid = 1'b1;
    @(negedge clk);
    wait_done4(n);
    check("b2b_first", n, frame_len(4) + 1);
    in_data = 8'hFF;
    @(negedge clk);
    check("b2b_start", int'(out_v[0]), 0);
    in_valid = 1'b0;
    wait_done4(n);
    check("b2b_second", n, frame_len(4) + 1);

    // Reset during cycle 20 of a 0x5A frame.
    wait_idle();
    send(8'h5A);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_out", int'(out_v[0]), 1);
    check("mid_rst_ready", int'(ready_v[0]), 1);
    check("mid_rst_busy", int'(busy_v[0]), 0);
    wait_idle();
    send(8'h5A);
    wait_done4(n);
    check("post_rst_frame", n, frame_len(4) + 1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 399) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = 8'($urandom);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (60) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
